// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read- and write-side controllers of the CDC FIFO.
// Narrower pointers are zero-extended to PTR_MAX_WIDTH; both conversions are exact under zero-extension.
package fifo_pkg;

  localparam int PTR_MAX_WIDTH      = 32;
  localparam int FIFO_ADDRESS_WIDTH = 4;

  // Default pointer type: one extra MSB beyond the address separates full from empty.
  typedef logic [FIFO_ADDRESS_WIDTH:0] fifo_ptr_t;
  typedef logic [PTR_MAX_WIDTH-1:0]    ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_WIDTH-1] = gray[PTR_MAX_WIDTH-1];
    for (int i = PTR_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/pointer_sync.sv
// Multi-bit flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit changes per source update, so the captured value is always a neighbouring pointer.
module pointer_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  // NOTE: these flops are reset (unlike the RAM array) so both domains restart from a known pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the CDC FIFO: synchronises the write pointer, derives empty/level,
// and fetches RAM words into a registered valid/ready output stage.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    ram_read_data,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic                     empty,
  output logic [ADDRESS_WIDTH:0]   level
);

  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] wgray_s;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic          fetch;

  pointer_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_write_pointer_sync (
    .clock (clock),
    .reset (reset),
    .d     (write_pointer_gray),
    .q     (wgray_s)
  );

  assign wbin_s       = PW'(gray2bin(ptr_word_t'(wgray_s)));
  assign rbin_next    = rbin + PW'(1);
  assign empty        = (read_pointer_gray == wgray_s);
  assign level        = wbin_s - rbin;
  assign read_address = rbin[ADDRESS_WIDTH-1:0];

  // Refill the output register whenever it is empty or being drained this cycle.
  assign fetch = !empty && (!read_valid || read_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      rbin              <= '0;
      read_pointer_gray <= '0;
      read_valid        <= 1'b0;
      read_data         <= '0;
    end else if (fetch) begin
      rbin              <= rbin_next;
      read_pointer_gray <= PW'(bin2gray(ptr_word_t'(rbin_next)));
      read_valid        <= 1'b1;
      read_data         <= ram_read_data;
    end else if (read_valid && read_ready) begin
      read_valid        <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the CDC FIFO. It sits in the read clock domain opposite the write-side logic and drives the read port of the shared dual-ported RAM. It synchronises the write-domain Gray pointer, derives empty/level, and fetches RAM words into a registered valid/ready output stage. It also publishes its own Gray read pointer so the write domain can compute full.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDRESS_WIDTH, 4, RAM address width; depth = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits
SYNC_STAGES, 2, flops in the write-pointer synchroniser (minimum 2)

Ports:
clock  input  1  read-domain clock
reset  input  1  synchronous, active-high reset
write_pointer_gray  input  ADDRESS_WIDTH+1  Gray write pointer from write domain (asynchronous)
read_pointer_gray  output  ADDRESS_WIDTH+1  registered Gray read pointer to write domain
read_address  output  ADDRESS_WIDTH  RAM read address
ram_read_data  input  DATA_WIDTH  RAM read data (combinational from read_address)
read_data  output  DATA_WIDTH  output word
read_valid  output  1  read_data holds a valid word
read_ready  input  1  consumer accepts word
empty  output  1  no unread words left in RAM (output register not counted)
level  output  ADDRESS_WIDTH+1  words in RAM not yet fetched, per synchronised pointer

Behaviour:
- Reset (clock edge with reset=1): synchroniser flops=0, binary read pointer rbin=0, read_pointer_gray=0, read_valid=0, read_data=0. Outputs derived from these give empty=1, level=0, read_address=0.
- Synchroniser: write_pointer_gray passes through SYNC_STAGES flops to give wgray_s, then Gray-to-binary gives wbin_s. No other logic touches the raw input.
- empty = (read_pointer_gray == wgray_s), combinational from registers.
- level = wbin_s - rbin, modulo 2**(ADDRESS_WIDTH+1). Range 0..2**ADDRESS_WIDTH.
- read_address = rbin[ADDRESS_WIDTH-1:0].
- Pop condition: fetch = !empty && (!read_valid || read_ready).
- On fetch: read_data <= ram_read_data; read_valid <= 1; rbin <= rbin+1; read_pointer_gray <= bin2gray(rbin+1).
- Else if read_valid && read_ready: read_valid <= 0; read_data holds its last value.
- Otherwise all state holds. read_data is stable while read_valid && !read_ready.
- read_ready while !read_valid: ignored.
- Simultaneous consume and fetch: the new word replaces the old in the same edge and read_valid stays 1. Back-to-back throughput is 1 word/cycle.
- Latency:
  - A write_pointer_gray change becomes visible in empty/level SYNC_STAGES cycles later.
  - read_valid rises 1 cycle after that.
  - Total from input pointer change to read_valid is SYNC_STAGES+1 edges.
- Wrap-around: rbin wraps naturally at 2**(ADDRESS_WIDTH+1). The address field wraps at depth. The extra MSB distinguishes a full FIFO from an empty one.
- Full FIFO (level = 2**ADDRESS_WIDTH) is a legal input state and drains normally.
- read_pointer_gray is a direct flop output (no combinational path), changes by exactly one bit per fetch, and never changes on any other edge.
- Reset mid-operation: all in-flight data is discarded, including the output register. The system must reset the write domain concurrently. This block does not detect a one-sided reset.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width.
  - pointer typedef helper (ADDRESS_WIDTH+1 bits).
  - Shared with the write-side controller.
- Sub-module pointer_sync: SYNC_STAGES-deep multi-bit flop synchroniser with synchronous reset to 0. Reused by the write side for the read pointer.

Test Plan:
- Reset with write_pointer_gray=0 -> empty=1, level=0, read_valid=0, read_pointer_gray=0, read_address=0; held for 10 cycles.
- Drive write_pointer_gray 0->1 (Gray 00001), RAM[0]=0xA5, read_ready=1 -> read_valid=1, read_data=0xA5 exactly 3 edges later (SYNC_STAGES=2). Next cycle read_valid=0, read_pointer_gray=00001.
- Preload 16 words 0x00..0x0F, set write_pointer_gray=bin2gray(16), read_ready=1 -> level reaches 16, then 16 consecutive valid cycles 0x00..0x0F. empty=1 and read_pointer_gray=11000 after drain.
- Same preload with read_ready=0 -> read_valid=1, read_data=0x00 held, level=15, rbin=1 frozen. Release read_ready -> stream resumes at 0x01 with no gap or duplicate.
- Run 40 words through with pointer wrap (rbin 31->0) and random read_ready -> in-order data, read_pointer_gray changes one bit per fetch, no read when empty.
- Assert reset mid-stream with read_valid=1 -> next edge read_valid=0, read_data=0, rbin=0, empty=1. Dropped words are not replayed.
